arbiter: RTL and testbench

// - Fair two-requester arbiter. Arbitrates a single shared resource between requester 1 and requester 2.
// - Grants are registered, one-hot or zero. Under contention, round-robin alternation prevents starvation.
// - Sits between two bus/master front-ends and the shared target. One clock domain, no CDC.

---
 rtl/arbiter_pkg.sv | 24 ++
 rtl/arbiter_if.sv | 23 ++
 rtl/arbiter_rr_core.sv | 57 +++++
 rtl/arbiter.sv | 89 ++++++++
 tb/tb_arbiter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the two-requester round-robin arbiter.
// The owner encoding is decoded directly into the one-hot grant outputs.
package arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_1,
    OWN_2
  } owner_e;

  // Priority pointer encoding: names the requester that wins the next contention.
  localparam logic PTR_1 = 1'b0;
  localparam logic PTR_2 = 1'b1;

  // Bit 0 is grant_1 and bit 1 is grant_2, so the result is never two-hot.
  function automatic logic [1:0] onehot_grant(input owner_e owner);
    logic [1:0] grant;
    grant    = 2'b00;
    grant[0] = (owner == OWN_1);
    grant[1] = (owner == OWN_2);
    return grant;
  endfunction

endpackage

// File: rtl/arbiter_if.sv
// Request/grant bundle between the two requester front-ends and the arbiter.
interface arbiter_if;

  logic req_1;
  logic req_2;
  logic grant_1;
  logic grant_2;

  modport master (
    output req_1,
    output req_2,
    input  grant_1,
    input  grant_2
  );

  modport slave (
    input  req_1,
    input  req_2,
    output grant_1,
    output grant_2
  );

endinterface

// File: rtl/arbiter_rr_core.sv
// Combinational next-state logic for the arbiter: this block chooses the next owner,
// updates the priority pointer and advances the hold counter.
module arbiter_rr_core
  import arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 1,
  parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic [1:0]        req,
  input  owner_e            owner,
  input  logic              ptr,
  input  logic [HOLD_W-1:0] hold_cnt,
  output owner_e            next_owner,
  output logic              next_ptr,
  output logic [HOLD_W-1:0] next_hold
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

  logic owner_active;

  assign owner_active = (owner == OWN_1) || (owner == OWN_2);

  // A grant won under contention already counts as one held cycle, so MAX_HOLD=1 alternates every cycle.
  always_comb begin
    next_owner = owner;
    next_ptr   = ptr;
    next_hold  = hold_cnt;
    case (req)
      2'b00: begin
        next_owner = OWN_NONE;
        next_hold  = '0;
      end
      2'b01: begin
        next_owner = OWN_1;
        next_ptr   = PTR_2;
        next_hold  = '0;
      end
      2'b10: begin
        next_owner = OWN_2;
        next_ptr   = PTR_1;
        next_hold  = '0;
      end
      default: begin
        if (owner_active && (hold_cnt < HOLD_LIMIT)) begin
          next_hold = hold_cnt + HOLD_ONE;
        end else begin
          next_owner = (ptr == PTR_2) ? OWN_2 : OWN_1;
          next_ptr   = ~ptr;
          next_hold  = HOLD_ONE;
        end
      end
    endcase
  end

endmodule

// File: rtl/arbiter.sv
// Fair two-requester arbiter with registered one-hot-or-zero grants.
// Under contention, round-robin alternation prevents either requester from being starved.
module arbiter
  import arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 1,
  parameter int PARK     = 0
) (
  input  logic      clk,
  input  logic      reset,
  arbiter_if.slave  bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  if (MAX_HOLD < 1 || PARK < 0 || PARK > 1) begin : g_bad_param
    $error("arbiter: MAX_HOLD must be >= 1 and PARK must be 0 or 1");
  end

  owner_e            owner;
  owner_e            next_owner;
  logic              ptr;
  logic              next_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] next_hold;
  logic [1:0]        grant_vec;

  arbiter_rr_core #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_core (
    .req        ({bus.req_2, bus.req_1}),
    .owner      (owner),
    .ptr        (ptr),
    .hold_cnt   (hold_cnt),
    .next_owner (next_owner),
    .next_ptr   (next_ptr),
    .next_hold  (next_hold)
  );

  // In reset the pointer favours requester 1, so requester 1 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner    <= OWN_NONE;
      ptr      <= PTR_1;
      hold_cnt <= '0;
    end else begin
      owner    <= next_owner;
      ptr      <= next_ptr;
      hold_cnt <= next_hold;
    end
  end

  assign grant_vec   = onehot_grant(owner);
  assign bus.grant_1 = grant_vec[0];
  assign bus.grant_2 = grant_vec[1];

`ifndef SYNTHESIS
  int unsigned wait_1;
  int unsigned wait_2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_1 <= 0;
      wait_2 <= 0;
    end else begin
      wait_1 <= (bus.req_1 && bus.req_2 && !bus.grant_1) ? wait_1 + 1 : 0;
      wait_2 <= (bus.req_1 && bus.req_2 && !bus.grant_2) ? wait_2 + 1 : 0;
    end
  end

  a_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(bus.grant_1 && bus.grant_2));

  a_grant_1_req: assert property (@(posedge clk) disable iff (!reset)
    bus.grant_1 |-> $past(bus.req_1));

  a_grant_2_req: assert property (@(posedge clk) disable iff (!reset)
    bus.grant_2 |-> $past(bus.req_2));

  // A continuously contending requester never waits longer than MAX_HOLD+1 edges.
  a_fair_1: assert property (@(posedge clk) disable iff (!reset)
    wait_1 <= MAX_HOLD + 1);

  a_fair_2: assert property (@(posedge clk) disable iff (!reset)
    wait_2 <= MAX_HOLD + 1);
`endif

endmodule

// File: tb/tb_arbiter.sv
// Directed, table-driven bench for the arbiter, with one instance at MAX_HOLD=1 and one at MAX_HOLD=3.
// The vector table and the hand-written sequences use hand-computed grant values.
module tb_arbiter;

  typedef struct {
    logic       r1;
    logic       r2;
    logic [1:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  vec_t vecs[15];

  arbiter_if bus1 ();
  arbiter_if bus3 ();

  arbiter #(.MAX_HOLD(1), .PARK(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  arbiter #(.MAX_HOLD(3), .PARK(0)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // act and exp are {grant_1, grant_2}.
  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: grant_1,grant_2 got %b required %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r1, input logic r2);
    @(negedge clk);
    bus1.req_1 = r1;
    bus1.req_2 = r2;
    @(posedge clk);
    #1;
  endtask

  // The reset pulse falls between clock edges, so arbitration restarts at the next posedge.
  task automatic pulseReset(input logic a1, input logic a2, input logic b1, input logic b2);
    @(negedge clk);
    reset = 1'b0;
    bus1.req_1 = a1;
    bus1.req_2 = a2;
    bus3.req_1 = b1;
    bus3.req_2 = b2;
    #3;
    reset = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus1.req_1 = 1'b0;
    bus1.req_2 = 1'b0;
    bus3.req_1 = 1'b0;
    bus3.req_2 = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 2'b10};
    vecs[1]  = '{1'b0, 1'b1, 2'b01};
    vecs[2]  = '{1'b0, 1'b0, 2'b00};
    vecs[3]  = '{1'b1, 1'b1, 2'b10};
    vecs[4]  = '{1'b1, 1'b1, 2'b01};
    vecs[5]  = '{1'b1, 1'b1, 2'b10};
    vecs[6]  = '{1'b1, 1'b0, 2'b10};
    vecs[7]  = '{1'b1, 1'b1, 2'b10};
    vecs[8]  = '{1'b1, 1'b1, 2'b01};
    vecs[9]  = '{1'b1, 1'b0, 2'b10};
    vecs[10] = '{1'b0, 1'b0, 2'b00};
    vecs[11] = '{1'b1, 1'b1, 2'b01};
    vecs[12] = '{1'b1, 1'b0, 2'b10};
    vecs[13] = '{1'b0, 1'b1, 2'b01};
    vecs[14] = '{1'b0, 1'b0, 2'b00};

    // While reset is held, the grants stay low before the first clock edge and while the requests toggle.
    #1;
    checkOutput("reset_pre_edge_mh1", {bus1.grant_1, bus1.grant_2}, 2'b00);
    checkOutput("reset_pre_edge_mh3", {bus3.grant_1, bus3.grant_2}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus1.req_1 = ~bus1.req_1;
      bus1.req_2 = 1'b1;
      bus3.req_1 = 1'b1;
      bus3.req_2 = ~bus3.req_2;
      @(posedge clk);
      #1;
      checkOutput($sformatf("reset_hold_mh1_%0d", i), {bus1.grant_1, bus1.grant_2}, 2'b00);
      checkOutput($sformatf("reset_hold_mh3_%0d", i), {bus3.grant_1, bus3.grant_2}, 2'b00);
    end
    @(negedge clk);
    bus1.req_1 = 1'b0;
    bus1.req_2 = 1'b0;
    bus3.req_1 = 1'b0;
    bus3.req_2 = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].r1, vecs[i].r2);
      checkOutput($sformatf("vec_%0d", i), {bus1.grant_1, bus1.grant_2}, vecs[i].exp);
    end

    // Under continuous contention from reset with MAX_HOLD=1, the grants alternate starting with requester 1.
    pulseReset(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("contend_mh1_%0d", i), {bus1.grant_1, bus1.grant_2},
                  (i % 2 == 0) ? 2'b10 : 2'b01);
    end

    // With MAX_HOLD=3, each requester holds the grant for three cycles.
    pulseReset(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("contend_mh3_%0d", i), {bus3.grant_1, bus3.grant_2},
                  ((i / 3) % 2 == 0) ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    bus3.req_1 = 1'b0;
    bus3.req_2 = 1'b0;

    // Asserting reset mid-grant clears the grants without a clock edge.
    applyStimulus(1'b1, 1'b0);
    checkOutput("midop_granted", {bus1.grant_1, bus1.grant_2}, 2'b10);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("midop_async_clear", {bus1.grant_1, bus1.grant_2}, 2'b00);
    bus1.req_2 = 1'b1;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midop_restart_first", {bus1.grant_1, bus1.grant_2}, 2'b10);
    @(posedge clk);
    #1;
    checkOutput("midop_restart_second", {bus1.grant_1, bus1.grant_2}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
